// File: rtl/iob_cache_backend_wtb.sv
// Cache back-end: register write-through buffer drained one entry per visit to WRITE,
// and a line-fill engine issuing one outstanding word read at a time, wrapping inside the line.
module iob_cache_backend_wtb #(
  parameter int BE_ADDR_W   = 32,
  parameter int BE_DATA_W   = 32,
  parameter int LINE_W      = 2,
  parameter int WTB_DEPTH_W = 3,
  localparam int BE_NBYTES  = BE_DATA_W / 8,
  localparam int RWORD_W    = (LINE_W > 0) ? LINE_W : 1
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   cke_i,
  input  logic                   fe_avalid_i,
  input  logic [BE_ADDR_W-1:0]   fe_addr_i,
  input  logic [BE_DATA_W-1:0]   fe_wdata_i,
  input  logic [BE_NBYTES-1:0]   fe_wstrb_i,
  output logic                   fe_ready_o,
  output logic [BE_DATA_W-1:0]   fe_rdata_o,
  output logic                   fe_rvalid_o,
  output logic [RWORD_W-1:0]     fe_rword_o,
  output logic                   fe_rlast_o,
  output logic                   be_avalid_o,
  output logic [BE_ADDR_W-1:0]   be_addr_o,
  output logic [BE_DATA_W-1:0]   be_wdata_o,
  output logic [BE_NBYTES-1:0]   be_wstrb_o,
  input  logic                   be_ready_i,
  input  logic [BE_DATA_W-1:0]   be_rdata_i,
  input  logic                   be_rvalid_i,
  output logic                   wtb_empty_o,
  output logic                   wtb_full_o,
  output logic [WTB_DEPTH_W:0]   wtb_level_o,
  output logic                   fill_busy_o
);

  localparam int OFF   = (BE_NBYTES > 1) ? $clog2(BE_NBYTES) : 0;
  localparam int DEPTH = 1 << WTB_DEPTH_W;
  localparam logic [BE_ADDR_W-1:0] LINE_MASK = BE_ADDR_W'((64'd1 << (LINE_W + OFF)) - 64'd1);
  localparam logic [RWORD_W-1:0]   LAST_WORD = RWORD_W'((1 << LINE_W) - 1);

  typedef struct packed {
    logic [BE_ADDR_W-1:0] addr;
    logic [BE_DATA_W-1:0] data;
    logic [BE_NBYTES-1:0] strb;
  } wtb_ent_t;

  typedef enum logic [1:0] {IDLE, WRITE, RD_REQ, RD_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [RWORD_W-1:0]     cnt_q, cnt_d;
  logic [BE_ADDR_W-1:0]   base_q, base_d;
  logic [WTB_DEPTH_W:0]   level_q, level_d;
  logic [WTB_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  wtb_ent_t               wtb_mem [DEPTH];
  wtb_ent_t               head;

  logic wr_req, empty, full, push, pop, rd_acc, rd_hs, beat;
  logic [BE_ADDR_W-1:0] rd_addr;

  assign head    = wtb_mem[rd_ptr_q];
  assign wr_req  = |fe_wstrb_i;
  assign empty   = (level_q == '0);
  assign full    = (level_q == (WTB_DEPTH_W+1)'(DEPTH));
  assign push    = cke_i & fe_avalid_i & wr_req & ~full;
  // Reads only enter when nothing is buffered, so they always observe earlier writes.
  assign rd_acc  = cke_i & fe_avalid_i & ~wr_req & empty & (state_q == IDLE);
  assign pop     = cke_i & (state_q == WRITE) & be_ready_i;
  assign rd_hs   = cke_i & (state_q == RD_REQ) & be_ready_i;
  // Data may return in the accept cycle itself; treat it exactly like RD_WAIT.
  assign beat    = cke_i & be_rvalid_i & (rd_hs | (state_q == RD_WAIT));
  assign rd_addr = base_q | ((BE_ADDR_W'(cnt_q) << OFF) & LINE_MASK);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    wr_ptr_d = wr_ptr_q + WTB_DEPTH_W'(push);
    rd_ptr_d = rd_ptr_q + WTB_DEPTH_W'(pop);
    level_d  = level_q + (WTB_DEPTH_W+1)'(push) - (WTB_DEPTH_W+1)'(pop);
    unique case (state_q)
      IDLE: begin
        if (cke_i & (push | ~empty)) begin
          state_d = WRITE;
        end else if (rd_acc) begin
          state_d = RD_REQ;
          base_d  = fe_addr_i & ~LINE_MASK;
          cnt_d   = '0;
        end
      end
      WRITE: if (pop) state_d = IDLE;
      RD_REQ, RD_WAIT: begin
        if (beat) begin
          if (cnt_q == LAST_WORD) begin
            state_d = IDLE;
          end else begin
            state_d = RD_REQ;
            cnt_d   = cnt_q + RWORD_W'(1);
          end
        end else if (rd_hs) begin
          state_d = RD_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by level and pointers.
  always_ff @(posedge clk_i) begin
    if (push) wtb_mem[wr_ptr_q] <= '{addr: fe_addr_i, data: fe_wdata_i, strb: fe_wstrb_i};
  end

  assign fe_ready_o  = push | rd_acc;
  assign fe_rdata_o  = be_rdata_i;
  assign fe_rvalid_o = beat;
  assign fe_rword_o  = cnt_q;
  assign fe_rlast_o  = beat & (cnt_q == LAST_WORD);

  assign be_avalid_o = (state_q == WRITE) | (state_q == RD_REQ);
  assign be_addr_o   = (state_q == WRITE) ? head.addr : rd_addr;
  assign be_wdata_o  = (state_q == WRITE) ? head.data : '0;
  assign be_wstrb_o  = (state_q == WRITE) ? head.strb : '0;

  assign wtb_empty_o = empty;
  assign wtb_full_o  = full;
  assign wtb_level_o = level_q;
  assign fill_busy_o = (state_q == RD_REQ) | (state_q == RD_WAIT);

endmodule

// File: tb/tb_iob_cache_backend_wtb.sv
// Directed bench for iob_cache_backend_wtb: transaction-level scoreboard checked every cycle,
// plus literal expectations for the write, full-buffer, fill, ordering and reset scenarios.
module tb_iob_cache_backend_wtb;

  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        cke_i = 1'b1;
  logic        fe_avalid_i;
  logic [31:0] fe_addr_i, fe_wdata_i;
  logic [3:0]  fe_wstrb_i;
  logic        fe_ready_o, fe_rvalid_o, fe_rlast_o;
  logic [31:0] fe_rdata_o;
  logic [1:0]  fe_rword_o;
  logic        be_avalid_o, be_ready_i, be_rvalid_i;
  logic [31:0] be_addr_o, be_wdata_o, be_rdata_i;
  logic [3:0]  be_wstrb_o;
  logic        wtb_empty_o, wtb_full_o, fill_busy_o;
  logic [3:0]  wtb_level_o;

  iob_cache_backend_wtb dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
    .fe_avalid_i(fe_avalid_i), .fe_addr_i(fe_addr_i), .fe_wdata_i(fe_wdata_i),
    .fe_wstrb_i(fe_wstrb_i), .fe_ready_o(fe_ready_o), .fe_rdata_o(fe_rdata_o),
    .fe_rvalid_o(fe_rvalid_o), .fe_rword_o(fe_rword_o), .fe_rlast_o(fe_rlast_o),
    .be_avalid_o(be_avalid_o), .be_addr_o(be_addr_o), .be_wdata_o(be_wdata_o),
    .be_wstrb_o(be_wstrb_o), .be_ready_i(be_ready_i), .be_rdata_i(be_rdata_i),
    .be_rvalid_i(be_rvalid_i), .wtb_empty_o(wtb_empty_o), .wtb_full_o(wtb_full_o),
    .wtb_level_o(wtb_level_o), .fill_busy_o(fill_busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Back-end memory: one-cycle read latency, or same-cycle data when same_mode is set.
  bit          same_mode = 0, hold_rv = 0, stray_rv = 0;
  logic        pend = 1'b0, rv_drv = 1'b0;
  logic [31:0] pend_addr = '0, rd_drv = '0;

  always @(negedge clk_i) begin
    pend      = arst_n_i && cke_i && be_avalid_o && be_ready_i && (be_wstrb_o == 4'h0) && !same_mode;
    pend_addr = be_addr_o;
  end
  always @(posedge clk_i) begin
    #1;
    rv_drv = pend && !hold_rv;
    rd_drv = memf(pend_addr);
  end
  assign be_rvalid_i = same_mode ? (be_avalid_o && be_ready_i && (be_wstrb_o == 4'h0)) : (rv_drv | stray_rv);
  assign be_rdata_i  = same_mode ? memf(be_addr_o) : rd_drv;

  // Scoreboard model: FIFO of pending writes, fill progress as request/response indices.
  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } went_t;
  went_t       wq[$];
  int          m_level = 0, m_widx = 0, m_ridx = 0, rlast_cnt = 0;
  bit          m_fill = 0;
  logic [31:0] m_base = '0;
  logic [31:0] wlog[$], rlog[$];
  int          rword_log[$];

  always @(negedge clk_i) begin : compare
    bit wr, exp_rdy, exp_rv;
    if (!arst_n_i) begin
      wq.delete(); m_level = 0; m_fill = 0; m_widx = 0; m_ridx = 0;
      chk("rst_be_avalid", be_avalid_o, 0);
      chk("rst_fe_rvalid", fe_rvalid_o, 0);
      chk("rst_fe_rlast", fe_rlast_o, 0);
      chk("rst_empty", wtb_empty_o, 1);
      chk("rst_full", wtb_full_o, 0);
      chk("rst_busy", fill_busy_o, 0);
      chk("rst_level", wtb_level_o, 0);
    end else begin
      wr = (fe_wstrb_i != 4'h0);
      chk("level", wtb_level_o, m_level);
      chk("empty", wtb_empty_o, m_level == 0);
      chk("full", wtb_full_o, m_level == 8);
      chk("fill_busy", fill_busy_o, m_fill);
      exp_rdy = cke_i && fe_avalid_i && (wr ? (m_level < 8) : (m_level == 0 && !m_fill));
      chk("fe_ready", fe_ready_o, exp_rdy);
      if (be_avalid_o && be_wstrb_o != 4'h0) begin
        chk("wr_during_fill", m_fill, 0);
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          chk("be_waddr", be_addr_o, wq[0].a);
          chk("be_wdata", be_wdata_o, wq[0].d);
          chk("be_wstrb", be_wstrb_o, wq[0].s);
          if (be_ready_i && cke_i) begin
            wlog.push_back(be_addr_o);
            void'(wq.pop_front());
            m_level--;
          end
        end
      end
      if (be_avalid_o && be_wstrb_o == 4'h0) begin
        chk("rd_outside_fill", m_fill, 1);
        chk("be_raddr", be_addr_o, m_base + 32'(m_widx * 4));
        chk("one_outstanding", m_widx, m_ridx);
        if (be_ready_i && cke_i) begin
          rlog.push_back(be_addr_o);
          m_widx++;
        end
      end
      exp_rv = cke_i && be_rvalid_i && m_fill && (m_widx > m_ridx);
      chk("fe_rvalid", fe_rvalid_o, exp_rv);
      if (fe_rlast_o) rlast_cnt++;
      if (exp_rv) begin
        chk("fe_rword", fe_rword_o, m_ridx);
        chk("fe_rdata", fe_rdata_o, memf(m_base + 32'(m_ridx * 4)));
        chk("fe_rlast", fe_rlast_o, m_ridx == 3);
        rword_log.push_back(int'(fe_rword_o));
        m_ridx++;
        if (m_ridx == 4) m_fill = 0;
      end else begin
        chk("fe_rlast_quiet", fe_rlast_o, 0);
      end
      if (exp_rdy) begin
        if (wr) begin
          wq.push_back('{a: fe_addr_i, d: fe_wdata_i, s: fe_wstrb_i});
          m_level++;
        end else begin
          m_fill = 1; m_base = fe_addr_i & ~32'hF; m_widx = 0; m_ridx = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic req(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    fe_avalid_i = v; fe_addr_i = a; fe_wdata_i = d; fe_wstrb_i = s;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    do begin @(negedge clk_i); c++; end while ((fill_busy_o || !wtb_empty_o || be_avalid_o) && c < 100);
    chk(name, {fill_busy_o, wtb_empty_o}, 2'b01);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    req(0, '0, '0, '0);
    be_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 arst_n_i = 1'b1;

    // Single write, immediately drained
    be_ready_i = 1'b1;
    req(1, 32'h10, 32'hAABBCCDD, 4'hF);
    @(negedge clk_i);
    chk("t020_ready_c0", fe_ready_o, 1);
    tick(); req(0, '0, '0, '0);
    @(negedge clk_i);
    chk("t020_avalid_c1", be_avalid_o, 1);
    chk("t020_addr_c1", be_addr_o, 32'h10);
    chk("t020_wdata_c1", be_wdata_o, 32'hAABBCCDD);
    chk("t020_level_c1", wtb_level_o, 1);
    @(negedge clk_i);
    chk("t020_level_c2", wtb_level_o, 0);

    // Fill the buffer with the back-end stalled, then drain in order
    tick(); be_ready_i = 1'b0; wlog.delete();
    for (int i = 0; i < 8; i++) begin
      req(1, 32'h100 + 32'(i * 4), 32'h1111_1111 * 32'(i + 1), (i % 2 == 1) ? 4'h3 : 4'hF);
      @(negedge clk_i);
      chk("t021_push_ready", fe_ready_o, 1);
      tick();
    end
    req(1, 32'h200, 32'hCAFE_0000, 4'hF);
    @(negedge clk_i);
    chk("t021_full", wtb_full_o, 1);
    chk("t021_level8", wtb_level_o, 8);
    chk("t021_9th_ready", fe_ready_o, 0);
    tick(); req(0, '0, '0, '0); be_ready_i = 1'b1;
    wait_idle("t021_drained");
    chk("t021_wcount", wlog.size(), 8);
    if (wlog.size() == 8) begin
      chk("t021_first", wlog[0], 32'h100);
      chk("t021_last", wlog[7], 32'h11C);
    end

    // Simultaneous push and pop at level 3 (pointers have wrapped by now)
    tick(); be_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(1, 32'h300 + 32'(i * 4), 32'h3000_0000 + 32'(i), 4'hF);
      tick();
    end
    req(1, 32'h30C, 32'h3000_0003, 4'hC); be_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t024_lvl_before", wtb_level_o, 3);
    chk("t024_head", be_addr_o, 32'h300);
    tick(); req(0, '0, '0, '0);
    @(negedge clk_i);
    chk("t024_lvl_after", wtb_level_o, 3);
    wait_idle("t024_drained");

    // Line fill from a mid-line address, with a write arriving during the fill
    tick(); rlog.delete(); rword_log.delete(); rlast_cnt = 0; wlog.delete();
    req(1, 32'h24, '0, 4'h0);
    @(negedge clk_i);
    chk("t022_rd_ready", fe_ready_o, 1);
    tick(); req(1, 32'h400, 32'h1234_5678, 4'hF);
    tick(); req(0, '0, '0, '0);
    wait_idle("t022_done");
    chk("t022_rcount", rlog.size(), 4);
    if (rlog.size() == 4) begin
      chk("t022_a0", rlog[0], 32'h20);
      chk("t022_a1", rlog[1], 32'h24);
      chk("t022_a2", rlog[2], 32'h28);
      chk("t022_a3", rlog[3], 32'h2C);
    end
    chk("t022_words", rword_log.size(), 4);
    if (rword_log.size() == 4) chk("t022_word3", rword_log[3], 3);
    chk("t022_rlast_once", rlast_cnt, 1);
    chk("t022_late_write", wlog.size(), 1);

    // Read stalls behind a pending write
    tick(); be_ready_i = 1'b0;
    req(1, 32'h500, 32'h5555_AAAA, 4'hF);
    tick(); req(1, 32'h34, '0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t023_stall", fe_ready_o, 0);
      tick();
    end
    be_ready_i = 1'b1;
    begin
      int c = 0;
      @(negedge clk_i);
      while (!fe_ready_o && c < 20) begin tick(); @(negedge clk_i); c++; end
    end
    chk("t023_accept", fe_ready_o, 1);
    chk("t023_empty_at_accept", wtb_empty_o, 1);
    tick(); req(0, '0, '0, '0);
    wait_idle("t023_done");

    // Read data returned in the same cycle as the request is accepted
    tick(); same_mode = 1; rlog.delete();
    req(1, 32'h48, '0, 4'h0);
    tick(); req(0, '0, '0, '0);
    wait_idle("tsame_done");
    chk("tsame_rcount", rlog.size(), 4);
    if (rlog.size() == 4) chk("tsame_a3", rlog[3], 32'h4C);
    tick(); same_mode = 0;

    // Clock enable low blocks acceptance
    cke_i = 1'b0; req(1, 32'h600, 32'h6666_6666, 4'hF);
    @(negedge clk_i);
    chk("tcke_ready", fe_ready_o, 0);
    tick(); cke_i = 1'b1;
    @(negedge clk_i);
    chk("tcke_resume", fe_ready_o, 1);
    tick(); req(0, '0, '0, '0);
    wait_idle("tcke_done");

    // Reset while waiting on word 1 of a fill, with a write buffered
    tick(); req(1, 32'h64, '0, 4'h0);
    tick(); req(1, 32'h700, 32'h7777_7777, 4'hF);
    tick(); req(0, '0, '0, '0);
    begin
      int c = 0;
      do begin @(negedge clk_i); c++; end while (!(fe_rvalid_o && fe_rword_o == 2'd0) && c < 20);
      chk("t025_word0_seen", fe_rvalid_o, 1);
    end
    hold_rv = 1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("t025_in_wait_busy", fill_busy_o, 1);
    chk("t025_in_wait_avalid", be_avalid_o, 0);
    chk("t025_buffered", wtb_level_o, 1);
    #2 arst_n_i = 1'b0;
    #1;
    chk("t025_be_avalid", be_avalid_o, 0);
    chk("t025_busy", fill_busy_o, 0);
    chk("t025_level", wtb_level_o, 0);
    chk("t025_empty", wtb_empty_o, 1);
    tick(); tick();
    arst_n_i = 1'b1; hold_rv = 0; stray_rv = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("t025_no_rvalid", fe_rvalid_o, 0);
      tick();
    end
    stray_rv = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
